// File: rtl/io_chan_seq.sv
// io_chan_seq: multi-channel character I/O sequencer.
//
// The sequencer binds to one of N_CHAN character devices under CPU command.
// In input mode it assembles CHAR_W-bit codes into signed words and pushes
// them into a small first-word-fall-through FIFO. In output mode it breaks
// CPU words into a sign char, NDIG magnitude digits (MSB first) and a MARK.
//
// Ports
//   CLOCK, rst                       clock, synchronous active-high reset
//   start, dir, sel, halt            command: begin / direction / channel / end
//   dev_in_data/valid/ready          per-channel device input chars
//   dev_out_data/valid/ready         shared output char, one-hot valid
//   word_in/_valid/_ready            CPU word to be emitted
//   word_out/_valid/_ready           FIFO head, popped on handshake
//   ready, done, overflow            idle, completion pulse, sticky digit loss
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start with a legal channel
// IN       | accepting chars from the bound device
// FLUSH    | pushing the assembled word, then back to IN or IDLE
// OUT_WAIT | waiting for a CPU word (or halt)
// EMIT     | presenting sign, digits and MARK to the bound device
module io_chan_seq #(
  parameter int N_CHAN     = 4,
  parameter int CHAR_W     = 5,
  parameter int WORD_W     = 29,
  parameter int FIFO_DEPTH = 4,
  parameter int SEL_W      = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic                     CLOCK,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     dir,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     halt,
  input  logic [N_CHAN*CHAR_W-1:0] dev_in_data,
  input  logic [N_CHAN-1:0]        dev_in_valid,
  output logic [N_CHAN-1:0]        dev_in_ready,
  output logic [CHAR_W-1:0]        dev_out_data,
  output logic [N_CHAN-1:0]        dev_out_valid,
  input  logic [N_CHAN-1:0]        dev_out_ready,
  input  logic [WORD_W-1:0]        word_in,
  input  logic                     word_in_valid,
  output logic                     word_in_ready,
  output logic [WORD_W-1:0]        word_out,
  output logic                     word_out_valid,
  input  logic                     word_out_ready,
  output logic                     ready,
  output logic                     done,
  output logic                     overflow
);

  localparam int DIG_W  = CHAR_W - 1;
  localparam int MAG_W  = WORD_W - 1;
  localparam int NDIG   = MAG_W / DIG_W;
  localparam int CNT_W  = $clog2(NDIG + 1);
  localparam int IDX_W  = $clog2(NDIG + 2);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [DIG_W-1:0] P_STOP  = DIG_W'(0);
  localparam logic [DIG_W-1:0] P_MARK  = DIG_W'(1);
  localparam logic [DIG_W-1:0] P_MINUS = DIG_W'(2);
  localparam logic [DIG_W-1:0] P_PLUS  = DIG_W'(3);
  localparam logic [SEL_W:0]   N_CHAN_V = (SEL_W + 1)'(N_CHAN);

  typedef enum logic [2:0] {
    S_IDLE, S_IN, S_FLUSH, S_OUT_WAIT, S_EMIT
  } state_t;

  state_t state, state_nxt;

  logic [SEL_W-1:0]  sel_q;
  logic [MAG_W-1:0]  asm_q;
  logic [CNT_W-1:0]  dig_cnt;
  logic              sign_q;
  logic              ovf_q;
  logic              ret_in_q;
  logic              halt_pend_q;
  logic [MAG_W-1:0]  out_mag;
  logic              out_sign;
  logic [IDX_W-1:0]  idx;
  logic              done_q;

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [FCNT_W-1:0] fcnt;

  logic [CHAR_W-1:0] ch;
  logic [DIG_W-1:0]  payload;
  logic              sel_ok, start_ok, in_fire, is_ctrl, is_data;
  logic              is_stop, is_mark, is_minus, is_plus, has_data;
  logic              fifo_full, push, pop, win_fire, out_fire, last_idx;
  logic [N_CHAN-1:0] chan_onehot;

  assign sel_ok      = ({1'b0, sel} < N_CHAN_V);
  assign start_ok    = (state == S_IDLE) && start && sel_ok;
  assign ch          = dev_in_data[sel_q*CHAR_W +: CHAR_W];
  assign payload     = ch[DIG_W-1:0];
  assign is_ctrl     = ch[CHAR_W-1];
  assign in_fire     = (state == S_IN) && !halt && dev_in_valid[sel_q];
  assign is_data     = in_fire && !is_ctrl;
  assign is_stop     = in_fire && is_ctrl && (payload == P_STOP);
  assign is_mark     = in_fire && is_ctrl && (payload == P_MARK);
  assign is_minus    = in_fire && is_ctrl && (payload == P_MINUS);
  assign is_plus     = in_fire && is_ctrl && (payload == P_PLUS);
  assign has_data    = (dig_cnt != '0) || sign_q;
  assign fifo_full   = (fcnt == FCNT_W'(FIFO_DEPTH));
  // A pop in the same cycle does not make room for a push when full.
  assign push        = (state == S_FLUSH) && !fifo_full;
  assign pop         = word_out_ready && (fcnt != '0);
  assign win_fire    = (state == S_OUT_WAIT) && word_in_valid && !halt && !halt_pend_q;
  assign out_fire    = (state == S_EMIT) && dev_out_ready[sel_q];
  assign last_idx    = (idx == IDX_W'(NDIG + 1));
  assign chan_onehot = N_CHAN'(1) << sel_q;

  // State register
  always_ff @(posedge CLOCK) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start_ok) state_nxt = dir ? S_OUT_WAIT : S_IN;
      S_IN: begin
        // halt behaves exactly like a received STOP
        if (halt || is_stop) state_nxt = has_data ? S_FLUSH : S_IDLE;
        else if (is_mark)    state_nxt = S_FLUSH;
      end
      S_FLUSH:    if (push) state_nxt = ret_in_q ? S_IN : S_IDLE;
      S_OUT_WAIT: begin
        if (halt || halt_pend_q) state_nxt = S_IDLE;
        else if (win_fire)       state_nxt = S_EMIT;
      end
      S_EMIT:     if (out_fire && last_idx) state_nxt = S_OUT_WAIT;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready         = (state == S_IDLE);
    done          = done_q;
    overflow      = ovf_q;
    dev_in_ready  = '0;
    dev_out_valid = '0;
    dev_out_data  = '0;
    word_in_ready = 1'b0;
    if (state == S_IN && !halt) dev_in_ready = chan_onehot;
    if (state == S_OUT_WAIT)    word_in_ready = !halt && !halt_pend_q;
    if (state == S_EMIT) begin
      dev_out_valid = chan_onehot;
      if (idx == '0)    dev_out_data = {1'b1, out_sign ? P_MINUS : P_PLUS};
      else if (last_idx) dev_out_data = {1'b1, P_MARK};
      else              dev_out_data = {1'b0, out_mag[MAG_W-1 -: DIG_W]};
    end
    word_out_valid = (fcnt != '0);
    word_out       = word_out_valid ? mem[rd_ptr] : '0;
  end

  // Assembly / disassembly datapath
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      sel_q       <= '0;
      asm_q       <= '0;
      dig_cnt     <= '0;
      sign_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ret_in_q    <= 1'b0;
      halt_pend_q <= 1'b0;
      out_mag     <= '0;
      out_sign    <= 1'b0;
      idx         <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (state != S_IDLE) && (state_nxt == S_IDLE);
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            sel_q       <= sel;
            asm_q       <= '0;
            dig_cnt     <= '0;
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
            halt_pend_q <= 1'b0;
          end
        end
        S_IN: begin
          if (is_data) begin
            asm_q <= MAG_W'({asm_q, payload});
            if (dig_cnt != CNT_W'(NDIG)) dig_cnt <= dig_cnt + CNT_W'(1);
            else if (asm_q[MAG_W-1 -: DIG_W] != '0) ovf_q <= 1'b1;
          end
          if (is_minus) sign_q <= 1'b1;
          if (is_plus)  sign_q <= 1'b0;
          if (state_nxt == S_FLUSH) ret_in_q <= is_mark;
        end
        S_FLUSH: begin
          if (push) begin
            asm_q   <= '0;
            dig_cnt <= '0;
            sign_q  <= 1'b0;
          end
        end
        S_OUT_WAIT: begin
          if (win_fire) begin
            out_mag  <= word_in[WORD_W-1:1];
            out_sign <= word_in[0];
            idx      <= '0;
          end
          if (state_nxt == S_IDLE) halt_pend_q <= 1'b0;
        end
        S_EMIT: begin
          // halt is remembered so the word in flight finishes with its MARK
          if (halt) halt_pend_q <= 1'b1;
          if (out_fire) begin
            idx <= idx + IDX_W'(1);
            if (idx != '0 && !last_idx) out_mag <= out_mag << DIG_W;
          end
        end
        default: ;
      endcase
    end
  end

  // Word FIFO pointers and occupancy
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      if (push && !pop)      fcnt <= fcnt + FCNT_W'(1);
      else if (pop && !push) fcnt <= fcnt - FCNT_W'(1);
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge CLOCK) begin
    if (push) mem[wr_ptr] <= {asm_q, sign_q};
  end

endmodule
